uart_tx_feeder: RTL and testbench
=================================

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 The block SHALL have parameter DATA_BW, default 8: width of one transmitted byte.
REQ-002 The block SHALL have parameter DEPTH, default 16: FIFO entries, power of two.
REQ-003 The block SHALL have parameter ADDR_BW, default 4: log2(DEPTH).
REQ-004 The block SHALL have port clk, input, 1: system clock (100 MHz).
REQ-005 The block SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 The block SHALL have port in_data, input, DATA_BW: producer byte.
REQ-007 The block SHALL have port in_valid, input, 1: producer byte valid.
REQ-008 The block SHALL have port in_last, input, 1: byte is last of a packet.
REQ-009 The block SHALL have port in_ready, output, 1: high when fill count < DEPTH.
REQ-010 The block SHALL have port tx_data, output, DATA_BW: byte to the UART transmitter, registered.
REQ-011 The block SHALL have port tx_transmit, output, 1: single-cycle transmit request.
REQ-012 The block SHALL have port tx_busy, input, 1: registered busy flag from the UART transmitter.
REQ-013 The block SHALL have port fifo_count, output, ADDR_BW+1: current fill level.

Function
REQ-014 A push SHALL occur on a clk edge with in_valid=1 and in_ready=1; {in_last, in_data} SHALL be stored at the tail.
REQ-015 When full, in_ready SHALL be 0 and no push SHALL occur; a pop in the same cycle frees space only from the next cycle.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH; fifo_count SHALL count 0..DEPTH; a simultaneous push and pop SHALL leave it unchanged.
REQ-017 The FSM SHALL have the states IDLE, SEND, WAIT_BUSY, WAIT_DONE and CHK.
REQ-018 In IDLE, if the FIFO is non-empty and tx_busy=0, the block SHALL pop the head into tx_data and the last-flag register, then go to SEND.
REQ-019 In SEND, tx_transmit SHALL be 1 for exactly one clk cycle, with tx_data stable, then the FSM SHALL go to WAIT_BUSY.
REQ-020 In WAIT_BUSY, the FSM SHALL remain until tx_busy=1 and then go to WAIT_DONE; tx_data SHALL stay stable throughout.
REQ-021 In WAIT_DONE, on tx_busy=0 the FSM SHALL go to CHK if the checksum is pending, otherwise to IDLE.
REQ-022 tx_transmit SHALL never assert outside SEND; there SHALL be at most one request per byte.
REQ-023 Latency from the first push into an empty FIFO with tx_busy=0 to tx_transmit=1 SHALL be 2 clk cycles.

Reset
REQ-024 On rst=1: FSM=IDLE, pointers=0, fifo_count=0, in_ready=1, tx_transmit=0, tx_data=0, checksum=0, pending flag=0.
REQ-025 A reset mid-transfer SHALL discard all FIFO contents and the partial checksum, with no further tx_transmit until new data arrives.

Configuration
REQ-026 With macro UART_TX_FEEDER_CHECKSUM_EN defined, the block SHALL XOR every byte into an 8-bit checksum as it is popped.
REQ-027 With the macro defined, popping a byte with last=1 SHALL set the checksum-pending flag.
REQ-028 With the macro defined, CHK SHALL load the checksum into tx_data, clear the checksum and the pending flag, and go to SEND; the checksum byte SHALL be sent after the last byte and before any following FIFO byte.
REQ-029 Without the macro, in_last SHALL be stored but ignored, CHK SHALL be unreachable, and no checksum logic SHALL be synthesized.

Structure
REQ-030 Package uart_pkg SHALL hold DATA_BW, the default DEPTH/ADDR_BW, and the FSM state enum, shared with the UART transmitter.
REQ-031 FIFO storage SHALL be one sub-module, sync_fifo (parameterised width DATA_BW+1, depth DEPTH); the FSM and checksum logic SHALL live in uart_tx_feeder.

Verification
REQ-032 Push 0xA5 into an empty FIFO with tx_busy=0 -> tx_data=0xA5; tx_transmit high 1 cycle, 2 cycles after the push.
REQ-033 Hold tx_busy=0 for 100 cycles after the request -> no second tx_transmit; FSM stays in WAIT_BUSY.
REQ-034 Push 17 bytes back-to-back with the UART stalled -> in_ready=0 after the 16th; fifo_count=16; the 17th is accepted only after the first pop.
REQ-035 With the macro defined, send packet 0x12,0x34,0x56 (last on 0x56) -> transmitted 0x12,0x34,0x56,0x70.
REQ-036 Assert rst during WAIT_DONE with 5 bytes queued -> fifo_count=0, in_ready=1, no tx_transmit after release.
REQ-037 Push and pop in the same cycle at fifo_count=DEPTH-1 -> fifo_count unchanged and data order preserved across pointer wrap.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default feeder FIFO geometry and the
// feeder FSM state encoding, also used by the UART transmitter.
// Latency: n/a (constants and types only). Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_BW = 8;   // width of one transmitted byte
    localparam int UART_DEPTH   = 16;  // default feeder FIFO entries
    localparam int UART_ADDR_BW = 4;   // log2(UART_DEPTH)

    // Fixed encodings kept as plain constants so older code that compares
    // against raw state values keeps working.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND      = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_CHK       = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_SEND      = ST_SEND,
        S_WAIT_BUSY = ST_WAIT_BUSY,
        S_WAIT_DONE = ST_WAIT_DONE,
        S_CHK       = ST_CHK
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with show-ahead head output and fill counter.
// Latency: a push is visible at o_data/o_count from the next clk edge.
// Backpressure: pushes while full and pops while empty are ignored.
// Ports: i_push/i_data write the tail, i_pop drops the head, o_data is the
//        current head, o_count the fill level 0..DEPTH, o_full/o_empty flags.
module sync_fifo #(
    parameter int WIDTH   = 9,
    parameter int DEPTH   = 16,
    parameter int ADDR_BW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_data,
    input  logic               i_pop,
    output logic [WIDTH-1:0]   o_data,
    output logic [ADDR_BW:0]   o_count,
    output logic               o_full,
    output logic               o_empty
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [ADDR_BW-1:0] r_wptr;
    logic [ADDR_BW-1:0] r_rptr;
    logic [ADDR_BW:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == (ADDR_BW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + ADDR_BW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ADDR_BW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_BW+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_BW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them one at a time to a UART transmitter.
// Latency: push into an empty FIFO -> tx_transmit high at the 2nd clk edge after.
// Backpressure: in_ready drops when the FIFO holds DEPTH bytes; tx_busy stalls pops.
// Ports: in_data/in_valid/in_last/in_ready producer side; tx_data/tx_transmit/
//        tx_busy transmitter side; fifo_count current fill level.
// Build option: define UART_TX_FEEDER_CHECKSUM_EN to append an XOR checksum
//        byte after every byte flagged in_last.
module uart_tx_feeder import uart_pkg::*; #(
    parameter int DATA_BW = UART_DATA_BW,
    parameter int DEPTH   = UART_DEPTH,
    parameter int ADDR_BW = UART_ADDR_BW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_BW-1:0] in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [DATA_BW-1:0] tx_data,
    output logic               tx_transmit,
    input  logic               tx_busy,
    output logic [ADDR_BW:0]   fifo_count
);

    uart_state_e        r_state;
    logic [DATA_BW-1:0] r_tx_data;
    logic [DATA_BW:0]   w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_chk_go;

    assign w_push      = in_valid & ~w_full;
    // Only take a new byte when idle and the transmitter has finished.
    assign w_pop       = (r_state == S_IDLE) & ~w_empty & ~tx_busy;
    assign in_ready    = ~w_full;
    assign tx_data     = r_tx_data;
    assign tx_transmit = (r_state == S_SEND);

    // Each entry carries {last, data}.
    sync_fifo #(
        .WIDTH   (DATA_BW + 1),
        .DEPTH   (DEPTH),
        .ADDR_BW (ADDR_BW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({in_last, in_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef UART_TX_FEEDER_CHECKSUM_EN
    logic [DATA_BW-1:0] r_csum;
    logic               r_csum_pend;

    // Checksum covers popped FIFO bytes only, never the checksum byte itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum      <= '0;
            r_csum_pend <= 1'b0;
        end else if (r_state == S_CHK) begin
            r_csum      <= '0;
            r_csum_pend <= 1'b0;
        end else if (w_pop) begin
            r_csum <= r_csum ^ w_head[DATA_BW-1:0];
            if (w_head[DATA_BW]) begin
                r_csum_pend <= 1'b1;
            end
        end
    end

    assign w_chk_go = r_csum_pend;
`else
    logic w_unused_last;

    assign w_unused_last = w_head[DATA_BW];
    assign w_chk_go      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tx_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_data <= w_head[DATA_BW-1:0];
                        r_state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_state <= S_WAIT_BUSY;
                end
                // Wait for the transmitter to acknowledge before watching
                // for completion, so one request never fires twice.
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_state <= w_chk_go ? S_CHK : S_IDLE;
                    end
                end
`ifdef UART_TX_FEEDER_CHECKSUM_EN
                S_CHK: begin
                    r_tx_data <= r_csum;
                    r_state   <= S_SEND;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: cycle table, directed corner cases,
// and randomized traffic against a byte-stream reference model.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_transmit;
    logic       tx_busy;
    logic [4:0] fifo_count;

    logic       uart_auto;
    logic       busy_man;
    logic       busy_model;
    int         m_lead;
    int         m_hold;
    logic       prev_tx;
    logic [7:0] sent_q[$];
    logic [7:0] exp_q[$];
    int         checks;
    int         errors;

    assign tx_busy = uart_auto ? busy_model : busy_man;

    uart_tx_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .tx_data     (tx_data),
        .tx_transmit (tx_transmit),
        .tx_busy     (tx_busy),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: after each request, idle 0..2 cycles then busy 1..5.
    always @(posedge clk) begin
        if (tx_transmit) begin
            m_lead <= $urandom_range(0, 2);
            m_hold <= $urandom_range(1, 5);
        end else if (m_lead > 0) begin
            m_lead <= m_lead - 1;
        end else if (m_hold > 0) begin
            busy_model <= 1'b1;
            m_hold     <= m_hold - 1;
        end else begin
            busy_model <= 1'b0;
        end
    end

    // Record every transmit request; a request must never last two cycles.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_transmit) begin
                checks++;
                if (prev_tx) begin
                    errors++;
                    $display("FAIL pulse_width: tx_transmit high on consecutive cycles, required single cycle");
                end
                sent_q.push_back(tx_data);
            end
            prev_tx = tx_transmit;
        end else begin
            prev_tx = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_sent(input int n, input int budget, input string name);
        int cyc;
        cyc = 0;
        while (sent_q.size() < n && cyc < budget) begin
            tick();
            cyc++;
        end
        checks++;
        if (sent_q.size() < n) begin
            errors++;
            $display("FAIL %s: timeout with %0d bytes sent, required %0d", name, sent_q.size(), n);
        end
    endtask

    task automatic settle_manual();
        repeat (20) tick();
        uart_auto = 1'b0;
        busy_man  = 1'b0;
    endtask

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic       busy;
        logic       exp_tx;
        logic [7:0] exp_data;
        logic [4:0] exp_cnt;
        logic       exp_rdy;
    } vec_t;

    vec_t vt[10];

    initial begin
        int n;
        int k;
        int acc;
        logic [7:0] csum;
        checks     = 0;
        errors     = 0;
        uart_auto  = 1'b0;
        busy_man   = 1'b0;
        busy_model = 1'b0;
        m_lead     = 0;
        m_hold     = 0;
        prev_tx    = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        rst        = 1'b1;

        // Reset values while reset is held.
        #7;
        chk("rst_count", fifo_count, 5'd0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_tx", tx_transmit, 1'b0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_state", dut.r_state, ST_IDLE);
        do_reset();

        // Cycle table: single byte 0xA5, then 0x3C pushed while busy.
        vt[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd1, 1'b1};
        vt[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1};
        vt[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1};
        vt[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1};
        vt[4] = '{1'b1, 8'h3C, 1'b1, 1'b0, 8'hA5, 5'd1, 1'b1};
        vt[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b1};
        vt[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 5'd0, 1'b1};
        vt[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 5'd0, 1'b1};
        vt[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 5'd0, 1'b1};
        vt[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 5'd0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            in_valid = vt[i].vld;
            in_data  = vt[i].dat;
            busy_man = vt[i].busy;
            tick();
            chk($sformatf("tab%0d_tx", i), tx_transmit, vt[i].exp_tx);
            chk($sformatf("tab%0d_data", i), tx_data, vt[i].exp_data);
            chk($sformatf("tab%0d_cnt", i), fifo_count, vt[i].exp_cnt);
            chk($sformatf("tab%0d_rdy", i), in_ready, vt[i].exp_rdy);
        end

        // Transmitter never acknowledges: exactly one request, parked in WAIT_BUSY.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n = sent_q.size();
        repeat (100) tick();
        chk("nobusy_pulses", sent_q.size(), n);
        chk("nobusy_state", dut.r_state, ST_WAIT_BUSY);
        chk("nobusy_data", tx_data, 8'h5A);
        busy_man = 1'b1;
        tick();
        busy_man = 1'b0;
        tick();
        tick();
        chk("nobusy_idle", dut.r_state, ST_IDLE);

        // 17 back-to-back pushes with the transmitter stalled.
        n = sent_q.size();
        busy_man = 1'b1;
        in_valid = 1'b1;
        k = 0;
        for (int i = 0; i < 22; i++) begin
            in_data = 8'(8'h40 + k);
            acc = int'(in_ready);
            tick();
            if (acc != 0) k++;
        end
        chk("full_accepted", k, 16);
        chk("full_count", fifo_count, 5'd16);
        chk("full_ready", in_ready, 1'b0);
        uart_auto = 1'b1;
        tick();
        chk("full_pop_count", fifo_count, 5'd15);
        chk("full_pop_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("full_refill", fifo_count, 5'd16);
        wait_sent(n + 17, 1000, "full_drain");
        for (int i = 0; i < 17; i++) begin
            if (n + i < sent_q.size()) chk($sformatf("full_seq%0d", i), sent_q[n+i], 8'(8'h40 + i));
        end
        settle_manual();

        // Simultaneous push and pop at DEPTH-1 across pointer wrap.
        n = sent_q.size();
        busy_man = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h80 + i);
            tick();
        end
        chk("wrap_count15", fifo_count, 5'd15);
        busy_man = 1'b0;
        in_data  = 8'h8F;
        tick();
        in_valid = 1'b0;
        chk("wrap_pushpop", fifo_count, 5'd15);
        uart_auto = 1'b1;
        wait_sent(n + 16, 1000, "wrap_drain");
        for (int i = 0; i < 16; i++) begin
            if (n + i < sent_q.size()) chk($sformatf("wrap_seq%0d", i), sent_q[n+i], 8'(8'h80 + i));
        end
        settle_manual();

`ifdef UART_TX_FEEDER_CHECKSUM_EN
        // Packet 12 34 56 must be followed by its checksum 0x70.
        do_reset();
        n = sent_q.size();
        uart_auto = 1'b1;
        in_valid  = 1'b1;
        in_data = 8'h12; in_last = 1'b0; tick();
        in_data = 8'h34; in_last = 1'b0; tick();
        in_data = 8'h56; in_last = 1'b1; tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_sent(n + 4, 500, "csum_drain");
        exp_q = '{8'h12, 8'h34, 8'h56, 8'h70};
        for (int i = 0; i < 4; i++) begin
            if (n + i < sent_q.size()) chk($sformatf("csum_seq%0d", i), sent_q[n+i], exp_q[i]);
        end
        settle_manual();
`endif

        // Reset while in WAIT_DONE with 5 bytes still queued.
        busy_man = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hC0 + i);
            tick();
        end
        in_valid = 1'b0;
        busy_man = 1'b0;
        tick();
        busy_man = 1'b1;
        tick();
        tick();
        chk("mid_state", dut.r_state, ST_WAIT_DONE);
        chk("mid_count", fifo_count, 5'd5);
        rst = 1'b1;
        #2;
        chk("mid_rst_count", fifo_count, 5'd0);
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_tx", tx_transmit, 1'b0);
        chk("mid_rst_data", tx_data, 8'h00);
        tick();
        rst      = 1'b0;
        busy_man = 1'b0;
        n = sent_q.size();
        repeat (30) tick();
        chk("mid_no_tx", sent_q.size(), n);
        chk("mid_idle", dut.r_state, ST_IDLE);

        // Randomized traffic against the byte-stream model.
        sent_q.delete();
        exp_q.delete();
        csum = 8'h00;
        uart_auto = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom_range(0, 255));
            in_last  = ($urandom_range(0, 3) == 0);
            chk("rnd_ready", in_ready, (fifo_count < 5'd16));
            acc = int'(in_valid && in_ready);
            if (acc != 0) begin
                exp_q.push_back(in_data);
`ifdef UART_TX_FEEDER_CHECKSUM_EN
                csum = csum ^ in_data;
                if (in_last) begin
                    exp_q.push_back(csum);
                    csum = 8'h00;
                end
`endif
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_sent(exp_q.size(), 8000, "rnd_drain");
        chk("rnd_len", sent_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < sent_q.size()) chk($sformatf("rnd_byte%0d", i), sent_q[i], exp_q[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
